// File: rtl/emulador_hcsr04.sv
// HC-SR04 responder model: accepts a qualified trigger pulse and, after the burst
// delay, drives an echo pulse whose width encodes the programmed distance.
module emulador_hcsr04 #(
    parameter int CICLOS_POR_CM  = 2941,
    parameter int TRIGGER_MIN    = 500,
    parameter int ATRASO_ECHO    = 10000,
    parameter int DIST_MIN       = 2,
    parameter int DIST_MAX       = 400,
    parameter int TIMEOUT_CICLOS = 1900000,
    parameter int RECUPERACAO    = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [8:0] distancia,
    output logic       echo,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    // One shared cycle counter serves every timed phase, so size it for the longest.
    localparam int M1    = (TIMEOUT_CICLOS > ATRASO_ECHO) ? TIMEOUT_CICLOS : ATRASO_ECHO;
    localparam int M2    = (M1 > RECUPERACAO) ? M1 : RECUPERACAO;
    localparam int M3    = (M2 > TRIGGER_MIN) ? M2 : TRIGGER_MIN;
    localparam int M4    = (M3 > CICLOS_POR_CM) ? M3 : CICLOS_POR_CM;
    localparam int CNT_W = $clog2(M4 + 1);

    localparam logic [CNT_W-1:0] TRIG_LIM     = CNT_W'(TRIGGER_MIN);
    localparam logic [CNT_W-1:0] ATRASO_LAST  = CNT_W'(ATRASO_ECHO - 1);
    localparam logic [CNT_W-1:0] CICLO_LAST   = CNT_W'(CICLOS_POR_CM - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CICLOS - 1);
    localparam logic [CNT_W-1:0] RECUP_LAST   = CNT_W'(RECUPERACAO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [8:0]       DMIN_L       = 9'(DIST_MIN);
    localparam logic [8:0]       DMAX_L       = 9'(DIST_MAX);

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        ESPERA       = 4'd1,
        MEDE_TRIGGER = 4'd2,
        ATRASO       = 4'd3,
        PULSO        = 4'd4,
        RECUPERA     = 4'd5
    } estado_t;

    estado_t           state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [8:0]        cm_q, cm_d;
    logic [8:0]        dist_q, dist_d;
    logic              echo_q, echo_d;
    logic              ocupado_q, ocupado_d;

    logic              timeout_sel;
    logic [8:0]        dist_eff;
    logic              fim_pulso;

    assign timeout_sel = (dist_q > DMAX_L);
    assign dist_eff    = (dist_q < DMIN_L) ? DMIN_L : dist_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= INICIAL;
            cnt_q     <= '0;
            cm_q      <= '0;
            dist_q    <= '0;
            echo_q    <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cm_q      <= cm_d;
            dist_q    <= dist_d;
            echo_q    <= echo_d;
            ocupado_q <= ocupado_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cm_d      = cm_q;
        dist_d    = dist_q;
        echo_d    = echo_q;
        ocupado_d = ocupado_q;
        fim_pulso = 1'b0;

        case (state_q)
            INICIAL: begin
                state_d = ESPERA;
                cnt_d   = '0;
            end
            ESPERA: begin
                if (trigger) begin
                    state_d = MEDE_TRIGGER;
                    cnt_d   = CNT_ONE;
                end
            end
            MEDE_TRIGGER: begin
                if (trigger) begin
                    if (cnt_q < TRIG_LIM) cnt_d = cnt_q + CNT_ONE;
                end else if (cnt_q >= TRIG_LIM) begin
                    dist_d    = distancia;
                    ocupado_d = 1'b1;
                    state_d   = ATRASO;
                    cnt_d     = '0;
                end else begin
                    state_d = ESPERA;
                    cnt_d   = '0;
                end
            end
            ATRASO: begin
                if (cnt_q == ATRASO_LAST) begin
                    state_d = PULSO;
                    echo_d  = 1'b1;
                    cnt_d   = '0;
                    cm_d    = dist_eff;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PULSO: begin
                // Width = cm count x cycles-per-cm via nested counters; timeout uses its own limit.
                if (timeout_sel) begin
                    if (cnt_q == TIMEOUT_LAST) fim_pulso = 1'b1;
                    else                       cnt_d = cnt_q + CNT_ONE;
                end else if (cnt_q == CICLO_LAST) begin
                    cnt_d = '0;
                    if (cm_q <= 9'd1) fim_pulso = 1'b1;
                    else              cm_d = cm_q - 9'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (fim_pulso) begin
                    echo_d  = 1'b0;
                    state_d = RECUPERA;
                    cnt_d   = '0;
                    cm_d    = '0;
                end
            end
            RECUPERA: begin
                if (cnt_q == RECUP_LAST) begin
                    ocupado_d = 1'b0;
                    state_d   = ESPERA;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = INICIAL;
                echo_d    = 1'b0;
                ocupado_d = 1'b0;
                cnt_d     = '0;
                cm_d      = '0;
            end
        endcase
    end

    assign echo      = echo_q;
    assign ocupado   = ocupado_q;
    assign db_estado = state_q;

endmodule

// File: tb/tb_emulador_hcsr04.sv
// Directed bench for emulador_hcsr04 with scaled-down timing parameters.
module tb_emulador_hcsr04;

    localparam int C     = 7;
    localparam int TMIN  = 5;
    localparam int ATR   = 20;
    localparam int DMIN  = 2;
    localparam int DMAX  = 400;
    localparam int TOUT  = 3000;
    localparam int RECUP = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       trigger = 1'b0;
    logic [8:0] distancia = 9'd10;
    logic       echo;
    logic       ocupado;
    logic [3:0] db_estado;

    int pass_cnt  = 0;
    int total_cnt = 0;

    emulador_hcsr04 #(
        .CICLOS_POR_CM (C),
        .TRIGGER_MIN   (TMIN),
        .ATRASO_ECHO   (ATR),
        .DIST_MIN      (DMIN),
        .DIST_MAX      (DMAX),
        .TIMEOUT_CICLOS(TOUT),
        .RECUPERACAO   (RECUP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .trigger  (trigger),
        .distancia(distancia),
        .echo     (echo),
        .ocupado  (ocupado),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // n cycles of trigger high, then the low sample that should accept it.
    task automatic do_trigger(input int n);
        trigger = 1'b1;
        repeat (n) tick();
        trigger = 1'b0;
        tick();
    endtask

    task automatic measure(output int d, output int w, output int r);
        d = 0;
        while (echo !== 1'b1 && d < 5000) begin tick(); d++; end
        w = 0;
        while (echo === 1'b1 && w < 5000) begin tick(); w++; end
        r = 0;
        while (ocupado === 1'b1 && r < 5000) begin tick(); r++; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        total_cnt++;
        if ({echo, ocupado, db_estado} !== {1'b0, 1'b0, 4'd0})
            $display("FAIL reset_state: echo=%0b ocupado=%0b db=%0d expected 0/0/0", echo, ocupado, db_estado);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (db_estado !== 4'd1)
            $display("FAIL reset_release: db=%0d expected 1", db_estado);
        else pass_cnt++;
        $display("reset: echo=%0b ocupado=%0b db=%0d", echo, ocupado, db_estado);
    endtask

    task automatic test_nominal();
        int d, w, r;
        distancia = 9'd10;
        do_trigger(TMIN);
        total_cnt++;
        if ({echo, ocupado, db_estado} !== {1'b0, 1'b1, 4'd3})
            $display("FAIL nominal_accept: echo=%0b ocupado=%0b db=%0d expected 0/1/3", echo, ocupado, db_estado);
        else pass_cnt++;
        measure(d, w, r);
        $display("nominal: dist=10 delay=%0d width=%0d recovery=%0d", d, w, r);
        total_cnt++;
        if (d !== ATR) $display("FAIL nominal_delay: got %0d expected %0d", d, ATR);
        else pass_cnt++;
        total_cnt++;
        if (w !== 10 * C) $display("FAIL nominal_width: got %0d expected %0d", w, 10 * C);
        else pass_cnt++;
        total_cnt++;
        if (r !== RECUP) $display("FAIL nominal_recovery: got %0d expected %0d", r, RECUP);
        else pass_cnt++;
        total_cnt++;
        if (db_estado !== 4'd1) $display("FAIL nominal_idle: db=%0d expected 1", db_estado);
        else pass_cnt++;
    endtask

    task automatic test_short();
        int d, w, r;
        int seen;
        distancia = 9'd10;
        do_trigger(TMIN - 1);
        total_cnt++;
        if (db_estado !== 4'd1) $display("FAIL short_return: db=%0d expected 1", db_estado);
        else pass_cnt++;
        seen = 0;
        repeat (4000) begin
            tick();
            if (echo !== 1'b0 || ocupado !== 1'b0) seen++;
        end
        $display("short: trigger=%0d cycles activity=%0d", TMIN - 1, seen);
        total_cnt++;
        if (seen !== 0) $display("FAIL short_ignored: active cycles %0d expected 0", seen);
        else pass_cnt++;
        do_trigger(TMIN);
        measure(d, w, r);
        $display("short_followup: delay=%0d width=%0d", d, w);
        total_cnt++;
        if (w !== 10 * C || d !== ATR)
            $display("FAIL short_followup: delay=%0d width=%0d expected %0d/%0d", d, w, ATR, 10 * C);
        else pass_cnt++;
    endtask

    task automatic test_range();
        int dists [6] = '{0, 1, 2, 400, 401, 511};
        int widths[6] = '{14, 14, 14, 2800, 3000, 3000};
        int d, w, r;
        for (int i = 0; i < 6; i++) begin
            distancia = 9'(dists[i]);
            do_trigger(TMIN);
            measure(d, w, r);
            $display("range: dist=%0d width=%0d", dists[i], w);
            total_cnt++;
            if (w !== widths[i])
                $display("FAIL range_width dist=%0d: got %0d expected %0d", dists[i], w, widths[i]);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_long_trigger();
        int d, w, r;
        distancia = 9'd3;
        trigger = 1'b1;
        repeat (60) tick();
        total_cnt++;
        if (db_estado !== 4'd2 || echo !== 1'b0)
            $display("FAIL long_hold: db=%0d echo=%0b expected 2/0", db_estado, echo);
        else pass_cnt++;
        trigger = 1'b0;
        tick();
        measure(d, w, r);
        $display("long_trigger: delay=%0d width=%0d", d, w);
        total_cnt++;
        if (d !== ATR || w !== 3 * C)
            $display("FAIL long_accept: delay=%0d width=%0d expected %0d/%0d", d, w, ATR, 3 * C);
        else pass_cnt++;
    endtask

    task automatic test_busy();
        int rises, rise_at, width;
        logic prev;
        distancia = 9'd10;
        do_trigger(TMIN);
        rises = 0; rise_at = -1; width = 0; prev = echo;
        for (int i = 1; i <= 150; i++) begin
            trigger = ((i >= 5 && i <= 12) || (i >= 40 && i <= 55)) ? 1'b1 : 1'b0;
            if (i == 50) distancia = 9'd50;
            tick();
            if (echo === 1'b1 && prev === 1'b0) begin rises++; rise_at = i; end
            if (echo === 1'b1) width++;
            prev = echo;
        end
        $display("busy: rises=%0d rise_at=%0d width=%0d db=%0d", rises, rise_at, width, db_estado);
        total_cnt++;
        if (rises !== 1) $display("FAIL busy_pulses: got %0d expected 1", rises);
        else pass_cnt++;
        total_cnt++;
        if (rise_at !== ATR) $display("FAIL busy_rise: got %0d expected %0d", rise_at, ATR);
        else pass_cnt++;
        total_cnt++;
        if (width !== 10 * C) $display("FAIL busy_latch_width: got %0d expected %0d", width, 10 * C);
        else pass_cnt++;
        total_cnt++;
        if (db_estado !== 4'd1 || ocupado !== 1'b0)
            $display("FAIL busy_idle: db=%0d ocupado=%0b expected 1/0", db_estado, ocupado);
        else pass_cnt++;
        distancia = 9'd10;
    endtask

    task automatic test_reset_mid_pulse();
        int n;
        distancia = 9'd10;
        do_trigger(TMIN);
        n = 0;
        while (echo !== 1'b1 && n < 5000) begin tick(); n++; end
        repeat (5) tick();
        total_cnt++;
        if (db_estado !== 4'd4 || echo !== 1'b1)
            $display("FAIL midpulse_pre: db=%0d echo=%0b expected 4/1", db_estado, echo);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        $display("reset_mid_pulse: echo=%0b ocupado=%0b db=%0d", echo, ocupado, db_estado);
        total_cnt++;
        if ({echo, ocupado, db_estado} !== {1'b0, 1'b0, 4'd0})
            $display("FAIL midpulse_reset: echo=%0b ocupado=%0b db=%0d expected 0/0/0", echo, ocupado, db_estado);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (db_estado !== 4'd1) $display("FAIL midpulse_release: db=%0d expected 1", db_estado);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short();
        test_range();
        test_long_trigger();
        test_busy();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/emulador_hcsr04.md
Name: emulador_hcsr04

Overview:
Synthesizable behavioural model of the HC-SR04 ultrasonic sensor. It is the responder end of the trigger/echo protocol that interface_hcsr04 initiates. It accepts a trigger pulse and, after a fixed burst delay, drives an echo pulse whose width encodes a programmed distance. It is used in the bench and on the board (switch-selected distance) to exercise the measurement chain without the physical sensor.

Parameters:
CICLOS_POR_CM, 2941, echo cycles per cm at 50 MHz (58.82 us/cm)
TRIGGER_MIN, 500, minimum consecutive trigger-high cycles for a valid trigger (10 us)
ATRASO_ECHO, 10000, cycles from trigger acceptance to echo rise (200 us burst)
DIST_MIN, 2, smallest reportable distance in cm
DIST_MAX, 400, largest reportable distance in cm
TIMEOUT_CICLOS, 1900000, echo width when there is no object (38 ms)
RECUPERACAO, 1000, hold-off cycles after echo falls before a new trigger is accepted

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
trigger  in  1  trigger from the initiator, treated as synchronous to clock
distancia  in  9  emulated distance in cm, unsigned binary
echo  out  1  echo pulse to the initiator
ocupado  out  1  high from trigger acceptance until the end of recovery
db_estado  out  4  current FSM state code

Behaviour:
- Reset is synchronous and active-high. It applies on the first clock edge with reset=1 and overrides everything, including mid-echo. After reset: state=inicial, echo=0, ocupado=0, all counters=0, db_estado=0.
- All outputs are registered. echo is never combinational from trigger.
- FSM states and codes:
  - inicial(0): unconditional next state espera(1).
  - espera(1): trigger=1 -> mede_trigger(2) with cnt_trig=1.
  - mede_trigger(2): trigger=1 increments cnt_trig, saturating at TRIGGER_MIN.
  - mede_trigger(2): trigger=0 with cnt_trig>=TRIGGER_MIN accepts the trigger. It latches dist_reg, sets ocupado=1 and goes to atraso(3).
  - mede_trigger(2): trigger=0 with cnt_trig<TRIGGER_MIN is a short pulse. It is ignored and the FSM returns to espera with no output change.
  - A trigger held high indefinitely is accepted on its fall.
  - atraso(3): counts ATRASO_ECHO cycles, then goes to pulso(4). echo rises on the first cycle in pulso, exactly ATRASO_ECHO cycles after the acceptance edge.
  - pulso(4): echo=1 for exactly W cycles, then echo=0 and the FSM goes to recupera(5).
  - recupera(5): counts RECUPERACAO cycles with ocupado=1, then ocupado=0 and the FSM goes to espera.
  - Any trigger activity in states 3-5 is ignored. A trigger still high on entry to espera is measured from that cycle.
- Echo width W, computed from dist_reg latched at acceptance:
  - dist_reg < DIST_MIN: W = DIST_MIN*CICLOS_POR_CM.
  - DIST_MIN <= dist_reg <= DIST_MAX: W = dist_reg*CICLOS_POR_CM.
  - dist_reg > DIST_MAX: W = TIMEOUT_CICLOS.
- W is produced with nested counters: a cycle counter wraps at CICLOS_POR_CM and a cm counter counts down from dist_reg. No multiplier. The timeout path uses the cycle counter with a separate limit.
- Changes on distancia after acceptance do not affect the current pulse.
- db_estado equals the state code. Unused codes 6-15 return to inicial on the next clock.

Test Plan:
1. Reset:
   - Assert reset during pulso with distancia=10 -> next edge echo=0, ocupado=0, db_estado=0.
   - Release reset -> db_estado=1 after one cycle.
2. Nominal pulse:
   - distancia=10, trigger high 500 cycles then low -> echo rises exactly 10000 cycles after the falling-edge sample.
   - echo stays high exactly 29410 cycles.
   - ocupado falls 1000 cycles after echo falls.
3. Short trigger:
   - trigger high 499 cycles -> no echo within 2,000,000 cycles; db_estado returns to 1.
   - A following 500-cycle trigger -> normal response.
4. Range limits:
   - distancia=0 -> echo 5882 cycles.
   - distancia=400 -> 1176400 cycles.
   - distancia=401 -> 1900000 cycles.
5. Busy and latching:
   - Retrigger during atraso and during pulso -> ignored; exactly one echo pulse.
   - Changing distancia 10->50 mid-pulse -> width stays 29410.
6. Loopback with interface_hcsr04:
   - Connect trigger/echo with distancia=25, pulse medir -> pronto asserts.
   - medida = 0x025 (BCD).
